// File: rtl/amem_wctl.sv
// CADR A-memory control: IR address decode, posted-write FIFO with drain on
// free RAM port cycles, and read forwarding from pending writes.
module amem_wctl #(
  parameter int AW       = 10,
  parameter int SAW      = 5,
  parameter int DW       = 32,
  parameter int WQ_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          state_decode,
  input  logic          state_write,
  input  logic [48:0]   ir,
  input  logic          dest,
  input  logic          destm,
  input  logic [DW-1:0] wdata,
  input  logic          port_busy,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW-1:0] ram_adr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  output logic          arp,
  output logic [DW-1:0] a_data,
  output logic          stall,
  output logic [3:0]    wq_count,
  output logic          wq_empty
);

  localparam int PW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;

  logic [AW-1:0] wadr;
  logic [AW-1:0] raddr;
  logic [AW-1:0] dest_adr;
  logic [AW-1:0] q_adr  [WQ_DEPTH];
  logic [DW-1:0] q_data [WQ_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] slot;
  logic [3:0]    count;
  logic          full;
  logic          push_req;
  logic          push;
  logic          drain;
  logic          unused_ir;

  // Only the address fields of the IR matter here.
  assign unused_ir = ^ir;

  assign raddr    = ir[32+AW-1:32];
  assign dest_adr = destm ? AW'(ir[14+SAW-1:14]) : ir[14+AW-1:14];

  assign full     = (count == 4'(WQ_DEPTH));
  assign wq_empty = (count == 4'd0);
  assign wq_count = count;
  assign push_req = state_write & dest;
  assign drain    = ~wq_empty & ~state_decode & ~port_busy;
  assign stall    = push_req & full & ~drain;
  assign push     = push_req & ~stall;

  assign arp       = state_decode;
  assign ram_we    = drain;
  assign ram_wdata = q_data[head];
  assign ram_adr   = drain ? q_adr[head] : raddr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(WQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wadr <= '0;
    end else if (state_decode) begin
      wadr <= dest_adr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= next_ptr(tail);
      if (drain) head <= next_ptr(head);
      case ({push, drain})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the count alone decides which slots are
  // live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_adr[tail]  <= wadr;
      q_data[tail] <= wdata;
    end
  end

  // NOTE: defaults first so no path through this block infers a latch.
  // Walk oldest to newest; the last match is the newest pending value.
  always_comb begin
    a_data = ram_rdata;
    slot   = head;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      slot = head + PW'(i);
      if ((4'(i) < count) && (q_adr[slot] == raddr)) begin
        a_data = q_data[slot];
      end
    end
  end

endmodule

// File: tb/tb_amem_wctl.sv
// Directed and random checks of amem_wctl against a behavioural RAM and an
// architectural A-memory reference model.
module tb_amem_wctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        state_decode;
  logic        state_write;
  logic [48:0] ir;
  logic        dest;
  logic        destm;
  logic [31:0] wdata;
  logic        port_busy;
  logic [31:0] ram_rdata;
  logic [9:0]  ram_adr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic        arp;
  logic [31:0] a_data;
  logic        stall;
  logic [3:0]  wq_count;
  logic        wq_empty;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram     [1024];
  logic [31:0] ref_mem [1024];
  logic        ram_init = 1'b0;

  always #5 clk = ~clk;

  amem_wctl dut (
    .clk(clk), .reset_n(reset_n), .state_decode(state_decode),
    .state_write(state_write), .ir(ir), .dest(dest), .destm(destm),
    .wdata(wdata), .port_busy(port_busy), .ram_rdata(ram_rdata),
    .ram_adr(ram_adr), .ram_we(ram_we), .ram_wdata(ram_wdata), .arp(arp),
    .a_data(a_data), .stall(stall), .wq_count(wq_count), .wq_empty(wq_empty)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
    end else if (ram_we) begin
      ram[ram_adr] <= ram_wdata;
    end
  end
  assign ram_rdata = ram[ram_adr];

  function automatic logic [48:0] make_ir(input logic [9:0] ra, input logic [9:0] df);
    logic [48:0] v;
    v = '0;
    v[41:32] = ra;
    v[23:14] = df;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    state_decode = 1'b0;
    state_write  = 1'b0;
    dest         = 1'b0;
    destm        = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] adr, input logic [31:0] data);
    state_decode = 1'b1;
    ir = make_ir(10'h000, adr);
    step();
    state_decode = 1'b0;
    state_write  = 1'b1;
    dest         = 1'b1;
    wdata        = data;
    step();
    go_idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    go_idle();
    ir = '0; wdata = '0; port_busy = 1'b0;
    ram_init = 1'b1;
    step();
    ram_init = 1'b0;
    #1;
    total++; if (ram_we !== 1'b0)    begin bad++; $display("FAIL reset_ram_we got=%0b exp=0", ram_we); end
    total++; if (stall !== 1'b0)     begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    total++; if (wq_count !== 4'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", wq_count); end
    total++; if (wq_empty !== 1'b1)  begin bad++; $display("FAIL reset_empty got=%0b exp=1", wq_empty); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_destm();
    state_decode = 1'b1;
    destm = 1'b1;
    ir = make_ir(10'h000, 10'h3FF);
    #1;
    total++; if (arp !== 1'b1) begin bad++; $display("FAIL destm_arp got=%0b exp=1", arp); end
    step();
    state_decode = 1'b0; destm = 1'b0;
    state_write = 1'b1; dest = 1'b1; wdata = 32'h0000_A5A5;
    #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL destm_no_same_cycle_drain got=%0b exp=0", ram_we); end
    step();
    go_idle();
    #1;
    total++; if (wq_count !== 4'd1) begin bad++; $display("FAIL destm_count got=%0d exp=1", wq_count); end
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL destm_we got=%0b exp=1", ram_we); end
    total++; if (ram_adr !== 10'h01F) begin bad++; $display("FAIL destm_adr got=%h exp=01f", ram_adr); end
    total++; if (ram_wdata !== 32'h0000_A5A5) begin bad++; $display("FAIL destm_wdata got=%h exp=0000a5a5", ram_wdata); end
    step();
    total++; if (ram[10'h01F] !== 32'h0000_A5A5) begin bad++; $display("FAIL destm_ram got=%h exp=0000a5a5", ram[10'h01F]); end
    total++; if (wq_empty !== 1'b1) begin bad++; $display("FAIL destm_empty got=%0b exp=1", wq_empty); end
  endtask

  task automatic test_forward();
    port_busy = 1'b1;
    do_write(10'h040, 32'h0000_0123);
    state_decode = 1'b1;
    ir = make_ir(10'h040, 10'h000);
    #1;
    total++; if (a_data !== 32'h0000_0123) begin bad++; $display("FAIL fwd_data got=%h exp=00000123", a_data); end
    step();
    go_idle();
    step();
    total++; if (ram[10'h040] !== init_val(10'h040)) begin bad++; $display("FAIL fwd_ram_held got=%h exp=%h", ram[10'h040], init_val(10'h040)); end
    port_busy = 1'b0;
    #1;
    total++; if (ram_adr !== 10'h040 || ram_we !== 1'b1) begin bad++; $display("FAIL fwd_drain adr=%h we=%0b exp adr=040 we=1", ram_adr, ram_we); end
    step();
    total++; if (ram[10'h040] !== 32'h0000_0123) begin bad++; $display("FAIL fwd_ram got=%h exp=00000123", ram[10'h040]); end
  endtask

  task automatic test_duplicate();
    port_busy = 1'b1;
    do_write(10'h010, 32'd1);
    do_write(10'h010, 32'd2);
    state_decode = 1'b1;
    ir = make_ir(10'h010, 10'h000);
    #1;
    total++; if (a_data !== 32'd2) begin bad++; $display("FAIL dup_newest got=%h exp=00000002", a_data); end
    total++; if (wq_count !== 4'd2) begin bad++; $display("FAIL dup_count got=%0d exp=2", wq_count); end
    step();
    go_idle();
    port_busy = 1'b0;
    step();
    step();
    total++; if (ram[10'h010] !== 32'd2) begin bad++; $display("FAIL dup_ram got=%h exp=00000002", ram[10'h010]); end
    total++; if (wq_empty !== 1'b1) begin bad++; $display("FAIL dup_empty got=%0b exp=1", wq_empty); end
  endtask

  task automatic test_full_stall();
    port_busy = 1'b1;
    do_write(10'h020, 32'h11);
    do_write(10'h021, 32'h22);
    state_decode = 1'b1;
    ir = make_ir(10'h000, 10'h022);
    step();
    state_decode = 1'b0;
    state_write = 1'b1; dest = 1'b1; wdata = 32'h33;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%0b exp=1", stall); end
    total++; if (wq_count !== 4'd2) begin bad++; $display("FAIL full_count got=%0d exp=2", wq_count); end
    step();
    total++; if (stall !== 1'b1 || wq_count !== 4'd2) begin bad++; $display("FAIL full_hold stall=%0b count=%0d exp 1/2", stall, wq_count); end
    port_busy = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL full_release_stall got=%0b exp=0", stall); end
    total++; if (ram_we !== 1'b1 || ram_adr !== 10'h020) begin bad++; $display("FAIL full_release_drain we=%0b adr=%h exp 1/020", ram_we, ram_adr); end
    step();
    go_idle();
    #1;
    total++; if (wq_count !== 4'd2) begin bad++; $display("FAIL full_count_kept got=%0d exp=2", wq_count); end
    total++; if (ram_adr !== 10'h021) begin bad++; $display("FAIL full_next_head got=%h exp=021", ram_adr); end
    step();
    step();
    total++; if (ram[10'h020] !== 32'h11 || ram[10'h021] !== 32'h22 || ram[10'h022] !== 32'h33) begin
      bad++; $display("FAIL full_ram_order got=%h %h %h exp=11 22 33", ram[10'h020], ram[10'h021], ram[10'h022]);
    end
    total++; if (wq_empty !== 1'b1) begin bad++; $display("FAIL full_empty got=%0b exp=1", wq_empty); end
  endtask

  task automatic test_reset_mid_drain();
    port_busy = 1'b1;
    do_write(10'h030, 32'h55);
    do_write(10'h031, 32'h66);
    port_busy = 1'b0;
    #1;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL rst_pre_drain got=%0b exp=1", ram_we); end
    reset_n = 1'b0;
    #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_async_we got=%0b exp=0", ram_we); end
    total++; if (wq_empty !== 1'b1 || wq_count !== 4'd0) begin bad++; $display("FAIL rst_async_fifo empty=%0b count=%0d exp 1/0", wq_empty, wq_count); end
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    step();
    total++; if (ram[10'h030] !== init_val(10'h030) || ram[10'h031] !== init_val(10'h031)) begin
      bad++; $display("FAIL rst_discard got=%h %h exp=%h %h", ram[10'h030], ram[10'h031], init_val(10'h030), init_val(10'h031));
    end
  endtask

  task automatic test_random();
    int          m_count;
    logic [9:0]  m_wadr;
    logic [9:0]  ra, df;
    logic [31:0] wd;
    logic        dm, dst, hold, m_drain, m_stall, m_push;
    int          op, errs;
    ram_init = 1'b1;
    step();
    ram_init = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    m_count = 0;
    m_wadr  = '0;
    hold    = 1'b0;
    op = 0; ra = '0; df = '0; wd = '0; dm = 1'b0; dst = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!hold) begin
        op  = $urandom_range(0, 2);
        ra  = ($urandom_range(0, 1) == 0) ? 10'(10'h100 + $urandom_range(0, 7)) : 10'($urandom_range(0, 7));
        df  = 10'(10'h100 + $urandom_range(0, 7)) ^ 10'($urandom_range(0, 1) << 9);
        dm  = ($urandom_range(0, 3) == 0);
        dst = ($urandom_range(0, 4) != 0);
        wd  = $urandom;
        df[4:3] = 2'b00;
      end
      port_busy    = ($urandom_range(0, 2) == 0);
      state_decode = (op == 1);
      state_write  = (op == 2);
      dest         = dst;
      destm        = dm;
      wdata        = wd;
      ir           = make_ir(ra, df);
      #1;
      m_drain = (m_count != 0) && (op != 1) && !port_busy;
      m_stall = (op == 2) && dst && (m_count == 2) && !m_drain;
      m_push  = (op == 2) && dst && !m_stall;
      total++; if (stall !== m_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, stall, m_stall); end
      total++; if (wq_count !== 4'(m_count)) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, wq_count, m_count); end
      if (op == 1) begin
        total++; if (a_data !== ref_mem[ra]) begin bad++; $display("FAIL rnd_a_data cyc=%0d adr=%h got=%h exp=%h", c, ra, a_data, ref_mem[ra]); end
      end
      step();
      if (m_push) ref_mem[m_wadr] = wd;
      m_count = m_count + (m_push ? 1 : 0) - (m_drain ? 1 : 0);
      if (op == 1) m_wadr = dm ? {5'b0, df[4:0]} : df;
      hold = m_stall;
    end
    go_idle();
    port_busy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    errs = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL rnd_final_ram got=%0d differing words exp=0", errs); end
    total++; if (wq_empty !== 1'b1) begin bad++; $display("FAIL rnd_final_empty got=%0b exp=1", wq_empty); end
  endtask

  initial begin
    test_reset();
    test_destm();
    test_forward();
    test_duplicate();
    test_full_stall();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
